// File: rtl/loop_pkg.sv
// Shared definitions for the hardware loop controller.
// Holds the default nesting depth and width, plus the default-width {pc, remaining}
// stack entry type.
package loop_pkg;

  localparam int unsigned LoopDepth = 4;
  localparam int unsigned LoopW     = 16;

  // One stack entry: the branch-back target and the iterations still to run.
  typedef struct packed {
    logic [LoopW-1:0] pc;
    logic [LoopW-1:0] remaining;
  } loop_entry_t;

  // Width of the occupancy count for a given depth. It must hold the value DEPTH itself.
  function automatic int unsigned depth_w(int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/loop_ctrl_if.sv
// Strobe/result bundle of the loop controller.
// master: the instruction sequencer. It drives loop_start/count_in/pc_in/loop_end and
//         receives the results.
// slave : the loop controller. It returns target_pc, branch_back, loop_exit, skip_body,
//         depth, ovf_err and unf_err.
interface loop_ctrl_if
  import loop_pkg::*;
#(
  parameter int unsigned DEPTH = LoopDepth,
  parameter int unsigned W     = LoopW
) ();

  logic                      loop_start;
  logic [W-1:0]              count_in;
  logic [W-1:0]              pc_in;
  logic                      loop_end;
  logic [W-1:0]              target_pc;
  logic                      branch_back;
  logic                      loop_exit;
  logic                      skip_body;
  logic [depth_w(DEPTH)-1:0] depth;
  logic                      ovf_err;
  logic                      unf_err;

  modport master (
    output loop_start, count_in, pc_in, loop_end,
    input  target_pc, branch_back, loop_exit, skip_body, depth, ovf_err, unf_err
  );

  modport slave (
    input  loop_start, count_in, pc_in, loop_end,
    output target_pc, branch_back, loop_exit, skip_body, depth, ovf_err, unf_err
  );

endinterface

// File: rtl/loop_stack_mem.sv
// Register-file LIFO for loop entries.
// Ports:
//   clk, rst_n       - clock, async active-low reset (clears all entries and the count)
//   push_i/_data_i   - write a new entry above the top (or replace the top when popping)
//   pop_i            - drop the top entry
//   wr_top_i/_data_i - overwrite the current top in place
//   top_o            - current top entry ('0 when empty)
//   full_o, empty_o  - occupancy flags
//   count_o          - number of valid entries
// The caller guarantees that pop_i and wr_top_i are never asserted together. It also
// guarantees that neither is asserted while the stack is empty, and that push_i is not
// asserted while the stack is full, unless the same cycle pops.
module loop_stack_mem
  import loop_pkg::*;
#(
  parameter int unsigned DEPTH   = LoopDepth,
  parameter type         entry_t = loop_entry_t,
  localparam int unsigned PtrW   = depth_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  input  logic            wr_top_i,
  input  entry_t          wr_top_data_i,
  output entry_t          top_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [PtrW-1:0] count_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] top_idx;
  logic [IdxW-1:0] push_idx;

  assign top_idx  = IdxW'(cnt_q - PtrW'(1));
  // Pop and push in the same cycle replace the top slot.
  assign push_idx = pop_i ? top_idx : IdxW'(cnt_q);

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == PtrW'(DEPTH));
  assign count_o = cnt_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (wr_top_i) begin
      mem_d[top_idx] = wr_top_data_i;
    end
    if (push_i) begin
      mem_d[push_idx] = push_data_i;
    end
    cnt_d = cnt_q + PtrW'(push_i) - PtrW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/loop_ctrl.sv
// Hardware loop controller.
// It captures the iteration count and return PC on loop entry. At each end of body it
// decides whether to branch back or to fall through.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   bus        - loop_ctrl_if.slave. Inputs: loop_start, count_in, pc_in, loop_end.
//                Registered outputs: target_pc, branch_back, loop_exit, skip_body, depth,
//                ovf_err, unf_err.
// When loop_start and loop_end arrive together, loop_end acts on the current top first
// and the new loop is then pushed above the result.
module loop_ctrl
  import loop_pkg::*;
#(
  parameter int unsigned DEPTH = LoopDepth,
  parameter int unsigned W     = LoopW
) (
  input  logic         clk,
  input  logic         rst_n,
  loop_ctrl_if.slave   bus
);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] remaining;
  } entry_t;

  localparam int unsigned PtrW = depth_w(DEPTH);

  entry_t          top;
  entry_t          push_data;
  entry_t          wr_top_data;
  logic            full, empty;
  logic [PtrW-1:0] count;
  logic            push, pop, wr_top;

  logic [W-1:0] target_pc_q, target_pc_d;
  logic         branch_back_q, branch_back_d;
  logic         loop_exit_q, loop_exit_d;
  logic         skip_body_q, skip_body_d;
  logic         ovf_err_q, ovf_err_d;
  logic         unf_err_q, unf_err_d;

  loop_stack_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_stack (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_data_i   (push_data),
    .pop_i         (pop),
    .wr_top_i      (wr_top),
    .wr_top_data_i (wr_top_data),
    .top_o         (top),
    .full_o        (full),
    .empty_o       (empty),
    .count_o       (count)
  );

  always_comb begin
    push                  = 1'b0;
    pop                   = 1'b0;
    wr_top                = 1'b0;
    push_data.pc          = bus.pc_in;
    push_data.remaining   = bus.count_in;
    wr_top_data.pc        = top.pc;
    wr_top_data.remaining = top.remaining - W'(1);
    target_pc_d           = target_pc_q;
    branch_back_d         = 1'b0;
    loop_exit_d           = 1'b0;
    skip_body_d           = 1'b0;
    ovf_err_d             = ovf_err_q;
    unf_err_d             = unf_err_q;

    if (bus.loop_end) begin
      if (empty) begin
        unf_err_d = 1'b1;
      end else if (top.remaining > W'(1)) begin
        wr_top        = 1'b1;
        branch_back_d = 1'b1;
        target_pc_d   = top.pc;
      end else begin
        // The last iteration finished, so the entry is dropped and never stores 0.
        pop         = 1'b1;
        loop_exit_d = 1'b1;
      end
    end

    if (bus.loop_start) begin
      if (bus.count_in == '0) begin
        skip_body_d = 1'b1;
      end else if (full && !pop) begin
        ovf_err_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_pc_q   <= '0;
      branch_back_q <= 1'b0;
      loop_exit_q   <= 1'b0;
      skip_body_q   <= 1'b0;
      ovf_err_q     <= 1'b0;
      unf_err_q     <= 1'b0;
    end else begin
      target_pc_q   <= target_pc_d;
      branch_back_q <= branch_back_d;
      loop_exit_q   <= loop_exit_d;
      skip_body_q   <= skip_body_d;
      ovf_err_q     <= ovf_err_d;
      unf_err_q     <= unf_err_d;
    end
  end

  assign bus.target_pc   = target_pc_q;
  assign bus.branch_back = branch_back_q;
  assign bus.loop_exit   = loop_exit_q;
  assign bus.skip_body   = skip_body_q;
  assign bus.depth       = count;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.unf_err     = unf_err_q;

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed self-checking bench for loop_ctrl with DEPTH=4 and W=16.
// Inputs are driven on the falling edge and outputs are checked on the next falling edge.
module tb_loop_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  loop_ctrl_if #(.DEPTH(4), .W(16)) bus ();

  loop_ctrl #(.DEPTH(4), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then stop at the falling edge where the results are visible.
  task automatic drive(input logic s, input logic [15:0] c, input logic [15:0] p,
                       input logic e);
    bus.loop_start = s;
    bus.count_in   = c;
    bus.pc_in      = p;
    bus.loop_end   = e;
    @(negedge clk);
    bus.loop_start = 1'b0;
    bus.loop_end   = 1'b0;
  endtask

  task automatic pulses(input string tag, input logic bb, input logic ex, input logic sk);
    chk({tag, "_bb"}, 32'(bus.branch_back), 32'(bb));
    chk({tag, "_exit"}, 32'(bus.loop_exit), 32'(ex));
    chk({tag, "_skip"}, 32'(bus.skip_body), 32'(sk));
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.loop_start = 1'b0;
    bus.loop_end   = 1'b0;
    bus.count_in   = '0;
    bus.pc_in      = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_target", 32'(bus.target_pc), 0);
    pulses("rst", 0, 0, 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    chk("rst_unf", 32'(bus.unf_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single loop: count=3, pc=0x0040
    drive(1, 16'd3, 16'h0040, 0);
    chk("l1_depth_push", 32'(bus.depth), 1);
    pulses("l1_push", 0, 0, 0);
    drive(0, 0, 0, 1);
    pulses("l1_end1", 1, 0, 0);
    chk("l1_end1_tgt", 32'(bus.target_pc), 32'h40);
    drive(0, 0, 0, 1);
    pulses("l1_end2", 1, 0, 0);
    chk("l1_end2_tgt", 32'(bus.target_pc), 32'h40);
    drive(0, 0, 0, 1);
    pulses("l1_end3", 0, 1, 0);
    chk("l1_end3_tgt_hold", 32'(bus.target_pc), 32'h40);
    chk("l1_depth_end", 32'(bus.depth), 0);
    drive(0, 0, 0, 0);
    pulses("l1_idle", 0, 0, 0);

    // Zero count skips the body
    drive(1, 16'd0, 16'h0099, 0);
    pulses("skip", 0, 0, 1);
    chk("skip_depth", 32'(bus.depth), 0);
    drive(0, 0, 0, 0);
    pulses("skip_idle", 0, 0, 0);

    // Nested loops: outer(2,0x0010), inner(2,0x0020)
    drive(1, 16'd2, 16'h0010, 0);
    drive(1, 16'd2, 16'h0020, 0);
    chk("nest_depth2", 32'(bus.depth), 2);
    drive(1, 16'd0, 16'h00AA, 1);  // skip_body coincides with branch_back
    pulses("nest_end1", 1, 0, 1);
    chk("nest_end1_tgt", 32'(bus.target_pc), 32'h20);
    chk("nest_end1_depth", 32'(bus.depth), 2);
    drive(0, 0, 0, 1);
    pulses("nest_end2", 0, 1, 0);
    chk("nest_end2_depth", 32'(bus.depth), 1);
    chk("nest_end2_tgt", 32'(bus.target_pc), 32'h20);
    drive(0, 0, 0, 1);
    pulses("nest_end3", 1, 0, 0);
    chk("nest_end3_tgt", 32'(bus.target_pc), 32'h10);
    drive(0, 0, 0, 1);
    pulses("nest_end4", 0, 1, 0);
    chk("nest_end4_depth", 32'(bus.depth), 0);

    // Pop with a push in the same cycle, then a decrement with a push in the same cycle
    drive(1, 16'd1, 16'h0030, 0);
    drive(1, 16'd5, 16'h0080, 1);
    pulses("sim_pop", 0, 1, 0);
    chk("sim_pop_depth", 32'(bus.depth), 1);
    drive(0, 0, 0, 1);
    pulses("sim_next", 1, 0, 0);
    chk("sim_next_tgt", 32'(bus.target_pc), 32'h80);
    drive(1, 16'd2, 16'h0090, 1);   // 0x80 remaining 4->3, push 0x90
    pulses("sim_dec", 1, 0, 0);
    chk("sim_dec_tgt", 32'(bus.target_pc), 32'h80);
    chk("sim_dec_depth", 32'(bus.depth), 2);
    drive(0, 0, 0, 1);
    chk("sim_in_tgt", 32'(bus.target_pc), 32'h90);
    drive(0, 0, 0, 1);
    pulses("sim_in_exit", 0, 1, 0);
    chk("sim_in_depth", 32'(bus.depth), 1);
    drive(0, 0, 0, 1);
    chk("sim_out_bb1", 32'(bus.branch_back), 1);
    drive(0, 0, 0, 1);
    chk("sim_out_bb2", 32'(bus.branch_back), 1);
    drive(0, 0, 0, 1);
    pulses("sim_out_exit", 0, 1, 0);
    chk("sim_out_depth", 32'(bus.depth), 0);

    // Overflow and underflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'd1, 16'(16'h0100 + i), 0);
    end
    chk("full_depth", 32'(bus.depth), 4);
    chk("full_ovf_pre", 32'(bus.ovf_err), 0);
    drive(1, 16'd1, 16'h0200, 0);
    chk("ovf_flag", 32'(bus.ovf_err), 1);
    chk("ovf_depth", 32'(bus.depth), 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
    end
    chk("drain_depth", 32'(bus.depth), 0);
    chk("drain_unf_pre", 32'(bus.unf_err), 0);
    drive(0, 0, 0, 1);
    chk("unf_flag", 32'(bus.unf_err), 1);
    pulses("unf", 0, 0, 0);
    chk("ovf_sticky", 32'(bus.ovf_err), 1);
    drive(0, 0, 0, 0);
    chk("unf_sticky", 32'(bus.unf_err), 1);

    // Asynchronous reset in the middle of a loop
    drive(1, 16'd3, 16'h0050, 0);
    drive(0, 0, 0, 1);
    chk("mid_bb", 32'(bus.branch_back), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bb", 32'(bus.branch_back), 0);
    chk("arst_tgt", 32'(bus.target_pc), 0);
    chk("arst_depth", 32'(bus.depth), 0);
    chk("arst_ovf", 32'(bus.ovf_err), 0);
    chk("arst_unf", 32'(bus.unf_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 1);
    chk("post_rst_unf", 32'(bus.unf_err), 1);
    pulses("post_rst", 0, 0, 0);
    chk("post_rst_depth", 32'(bus.depth), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
